// File: rtl/boot_heartbeat_monitor_pkg.sv
// -----------------------------------------------------------------------------
// boot_heartbeat_monitor_pkg
//   Shared types and constants for the boot heartbeat monitor:
//   - state_t : monitor FSM states
//   - FC_*    : fail codes driven on the fail_code status pins
// -----------------------------------------------------------------------------
package boot_heartbeat_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FIRST = 2'd1,
        MEASURE    = 2'd2,
        FAIL       = 2'd3
    } state_t;

    localparam logic [1:0] FC_NONE   = 2'b00;  // no violation
    localparam logic [1:0] FC_NOEDGE = 2'b01;  // no first edge before timeout
    localparam logic [1:0] FC_SHORT  = 2'b10;  // half-period below minimum
    localparam logic [1:0] FC_LONG   = 2'b11;  // half-period above maximum

endpackage

// File: rtl/boot_heartbeat_monitor_if.sv
// -----------------------------------------------------------------------------
// boot_heartbeat_monitor_if
//   Groups the monitor's control input, heartbeat input and status outputs.
//   master : drives en / hb_in, observes the status
//   slave  : the monitor itself
//   Signals: en, hb_in (to monitor); pass, fail, fail_code, toggle_cnt,
//            last_half, busy, dbg_state (from monitor).
// -----------------------------------------------------------------------------
interface boot_heartbeat_monitor_if #(
    parameter int CNT_W = 16
);
    import boot_heartbeat_monitor_pkg::*;

    logic             en;
    logic             hb_in;
    logic             pass;
    logic             fail;
    logic [1:0]       fail_code;
    logic [7:0]       toggle_cnt;
    logic [CNT_W-1:0] last_half;
    logic             busy;
    state_t           dbg_state;

    modport master (
        output en, hb_in,
        input  pass, fail, fail_code, toggle_cnt, last_half, busy, dbg_state
    );

    modport slave (
        input  en, hb_in,
        output pass, fail, fail_code, toggle_cnt, last_half, busy, dbg_state
    );

endinterface

// File: rtl/boot_heartbeat_monitor_edge_detect.sv
// -----------------------------------------------------------------------------
// boot_heartbeat_monitor_edge_detect
//   One-flop edge detector reporting both polarities.
//   Ports: clk, rst_n (async active-low), d (sampled signal),
//          clr (suppress the report this cycle; the flop still samples),
//          pulse (high for one cycle when d differs from its last sample).
// -----------------------------------------------------------------------------
module boot_heartbeat_monitor_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    input  logic clr,
    output logic pulse
);

    logic d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign pulse = ~clr & (d ^ d_q);

endmodule

// File: rtl/boot_heartbeat_monitor.sv
// -----------------------------------------------------------------------------
// boot_heartbeat_monitor
//   Watches the boot program's heartbeat toggle and checks that every
//   half-period (edge-to-edge distance in clk cycles) lies within
//   [MIN_HALF, MAX_HALF]. Raises sticky pass/fail flags and a fail code.
//   Ports: clk, rst_n (async active-low), mon (slave modport): en, hb_in in;
//          pass, fail, fail_code, toggle_cnt, last_half, busy, dbg_state out.
// -----------------------------------------------------------------------------
module boot_heartbeat_monitor
    import boot_heartbeat_monitor_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MIN_HALF    = 256,
    parameter int MAX_HALF    = 61440,
    parameter int FIRST_TMO   = 65535,
    parameter int REQ_TOGGLES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    boot_heartbeat_monitor_if.slave  mon
);

    localparam int GOOD_W = $clog2(REQ_TOGGLES + 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic [7:0]        toggle_q, toggle_d;
    logic [CNT_W-1:0]  last_half_q, last_half_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic [1:0]        code_q, code_d;

    logic              arm;
    logic              hb_edge;
    logic [CNT_W-1:0]  cnt_inc;
    logic [7:0]        toggle_inc;
    logic [CNT_W:0]    half;       // one extra bit so cnt+1 never wraps
    logic [CNT_W-1:0]  half_sat;

    // The arm cycle is the IDLE cycle with en high; its edge report is masked.
    assign arm = (state_q == IDLE) && mon.en;

    boot_heartbeat_monitor_edge_detect u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (mon.hb_in),
        .clr   (arm),
        .pulse (hb_edge)
    );

    assign cnt_inc    = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    assign toggle_inc = (toggle_q == 8'hFF) ? toggle_q : toggle_q + 8'd1;
    assign half       = {1'b0, cnt_q} + 1'b1;
    assign half_sat   = half[CNT_W] ? {CNT_W{1'b1}} : half[CNT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            good_q      <= '0;
            toggle_q    <= '0;
            last_half_q <= '0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            code_q      <= FC_NONE;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            good_q      <= good_d;
            toggle_q    <= toggle_d;
            last_half_q <= last_half_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            code_q      <= code_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        good_d      = good_q;
        toggle_d    = toggle_q;
        last_half_d = last_half_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        code_d      = code_q;

        if (!mon.en) begin
            // Status is held for software; only the FSM and counter drop back.
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d     = WAIT_FIRST;
                    cnt_d       = '0;
                    good_d      = '0;
                    toggle_d    = '0;
                    last_half_d = '0;
                    pass_d      = 1'b0;
                    fail_d      = 1'b0;
                    code_d      = FC_NONE;
                end
                WAIT_FIRST: begin
                    // An edge wins over the timeout in the same cycle.
                    if (hb_edge) begin
                        state_d  = MEASURE;
                        cnt_d    = '0;
                        toggle_d = toggle_inc;
                    end else if (cnt_q == CNT_W'(FIRST_TMO)) begin
                        state_d = FAIL;
                        fail_d  = 1'b1;
                        code_d  = FC_NOEDGE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                MEASURE: begin
                    if (hb_edge) begin
                        cnt_d       = '0;
                        toggle_d    = toggle_inc;
                        last_half_d = half_sat;
                        if (half < (CNT_W+1)'(MIN_HALF)) begin
                            state_d = FAIL;
                            fail_d  = 1'b1;
                            code_d  = FC_SHORT;
                        end else if (good_q != GOOD_W'(REQ_TOGGLES)) begin
                            good_d = good_q + 1'b1;
                            if (good_q + 1'b1 == GOOD_W'(REQ_TOGGLES)) begin
                                pass_d = 1'b1;
                            end
                        end
                    end else if (half > (CNT_W+1)'(MAX_HALF)) begin
                        // Too long is flagged as soon as the limit passes.
                        state_d = FAIL;
                        fail_d  = 1'b1;
                        code_d  = FC_LONG;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                FAIL: begin
                    // Terminal until en drops; everything frozen.
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign mon.pass       = pass_q;
    assign mon.fail       = fail_q;
    assign mon.fail_code  = code_q;
    assign mon.toggle_cnt = toggle_q;
    assign mon.last_half  = last_half_q;
    assign mon.busy       = (state_q == WAIT_FIRST) || (state_q == MEASURE);
    assign mon.dbg_state  = state_q;

endmodule

// File: tb/tb_boot_heartbeat_monitor.sv
// -----------------------------------------------------------------------------
// tb_boot_heartbeat_monitor
//   Directed bench: a table of heartbeat scenarios with hand-computed
//   expected status, followed by hand-written multi-cycle sequences for
//   en drop/re-arm, frozen fail code and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_boot_heartbeat_monitor;
    import boot_heartbeat_monitor_pkg::*;

    localparam int CNT_W       = 16;
    localparam int MIN_HALF    = 4;
    localparam int MAX_HALF    = 20;
    localparam int FIRST_TMO   = 50;
    localparam int REQ_TOGGLES = 4;
    localparam int NVEC        = 13;

    logic clk;
    logic rst_n;

    boot_heartbeat_monitor_if #(.CNT_W(CNT_W)) bus ();

    boot_heartbeat_monitor #(
        .CNT_W       (CNT_W),
        .MIN_HALF    (MIN_HALF),
        .MAX_HALF    (MAX_HALF),
        .FIRST_TMO   (FIRST_TMO),
        .REQ_TOGGLES (REQ_TOGGLES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mon   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        string      name;
        int         first_gap;    // cycles in WAIT_FIRST before the first edge
        int         half;         // spacing of the following edges
        int         n_edges;      // total edges including the first
        int         tail_half;    // extra phase after the edges
        bit         tail_toggle;  // 1: edge after tail_half cycles, 0: just hold
        bit         exp_pass;
        bit         exp_fail;
        logic [1:0] exp_code;
        int         exp_last_half;
        int         exp_toggle;
        bit         exp_busy;
    } vec_t;

    vec_t vecs[NVEC];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic toggle_tick();
        bus.hb_in = ~bus.hb_in;
        tick();
    endtask

    task automatic run_vec(input vec_t v);
        bus.en = 1'b0;
        repeat (2) tick();
        bus.en = 1'b1;
        tick();                                // arm cycle
        repeat (v.first_gap) tick();
        if (v.n_edges > 0) begin
            toggle_tick();
            for (int i = 1; i < v.n_edges; i++) begin
                repeat (v.half - 1) tick();
                toggle_tick();
            end
        end
        if (v.tail_toggle) begin
            repeat (v.tail_half - 1) tick();
            toggle_tick();
        end else begin
            repeat (v.tail_half) tick();
        end
        check({v.name, ".pass"},      int'(bus.pass),       int'(v.exp_pass));
        check({v.name, ".fail"},      int'(bus.fail),       int'(v.exp_fail));
        check({v.name, ".code"},      int'(bus.fail_code),  int'(v.exp_code));
        check({v.name, ".last_half"}, int'(bus.last_half),  v.exp_last_half);
        check({v.name, ".toggles"},   int'(bus.toggle_cnt), v.exp_toggle);
        check({v.name, ".busy"},      int'(bus.busy),       int'(v.exp_busy));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".pass"},      int'(bus.pass),       0);
        check({tag, ".fail"},      int'(bus.fail),       0);
        check({tag, ".code"},      int'(bus.fail_code),  0);
        check({tag, ".toggles"},   int'(bus.toggle_cnt), 0);
        check({tag, ".last_half"}, int'(bus.last_half),  0);
        check({tag, ".busy"},      int'(bus.busy),       0);
        check({tag, ".state"},     int'(bus.dbg_state),  int'(IDLE));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        //               name                gap half edges tail ttog  pass fail code       last tog busy
        vecs[0]  = '{"pass_basic",        5, 10,   5,   0, 1'b0, 1'b1, 1'b0, FC_NONE,   10,   5, 1'b1};
        vecs[1]  = '{"one_short_of_req",  5, 10,   4,   0, 1'b0, 1'b0, 1'b0, FC_NONE,   10,   4, 1'b1};
        vecs[2]  = '{"no_first_edge",    60,  0,   0,   0, 1'b0, 1'b0, 1'b1, FC_NOEDGE,  0,   0, 1'b0};
        vecs[3]  = '{"tmo_not_yet",      50,  0,   0,   0, 1'b0, 1'b0, 1'b0, FC_NONE,    0,   0, 1'b1};
        vecs[4]  = '{"tmo_exact",        51,  0,   0,   0, 1'b0, 1'b0, 1'b1, FC_NOEDGE,  0,   0, 1'b0};
        vecs[5]  = '{"edge_at_tmo",      50,  0,   1,   0, 1'b0, 1'b0, 1'b0, FC_NONE,    0,   1, 1'b1};
        vecs[6]  = '{"short_half",        3, 10,   3,   3, 1'b1, 1'b0, 1'b1, FC_SHORT,   3,   4, 1'b0};
        vecs[7]  = '{"min_half_legal",    2,  4,   5,   0, 1'b0, 1'b1, 1'b0, FC_NONE,    4,   5, 1'b1};
        vecs[8]  = '{"max_half_legal",    2, 20,   5,   0, 1'b0, 1'b1, 1'b0, FC_NONE,   20,   5, 1'b1};
        vecs[9]  = '{"long_after_pass",   2, 10,   5,  21, 1'b0, 1'b1, 1'b1, FC_LONG,   10,   5, 1'b0};
        vecs[10] = '{"hold_max_ok",       2, 10,   5,  20, 1'b0, 1'b1, 1'b0, FC_NONE,   10,   5, 1'b1};
        vecs[11] = '{"short_after_pass",  2,  4,   5,   3, 1'b1, 1'b1, 1'b1, FC_SHORT,   3,   6, 1'b0};
        vecs[12] = '{"saturate_toggles",  1,  8, 300,   0, 1'b0, 1'b1, 1'b0, FC_NONE,    8, 255, 1'b1};

        rst_n     = 1'b0;
        bus.en    = 1'b0;
        bus.hb_in = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i]);
        end

        // en drop mid-MEASURE (after the saturation vector): status held.
        bus.en = 1'b0;
        tick();
        check("en_drop.busy",    int'(bus.busy),       0);
        check("en_drop.state",   int'(bus.dbg_state),  int'(IDLE));
        check("en_drop.pass",    int'(bus.pass),       1);
        check("en_drop.toggles", int'(bus.toggle_cnt), 255);
        // Re-arm clears the status and enters WAIT_FIRST.
        bus.en = 1'b1;
        tick();
        check("rearm.state",     int'(bus.dbg_state),  int'(WAIT_FIRST));
        check("rearm.busy",      int'(bus.busy),       1);
        check("rearm.pass",      int'(bus.pass),       0);
        check("rearm.toggles",   int'(bus.toggle_cnt), 0);
        check("rearm.last_half", int'(bus.last_half),  0);

        // Timeout, then edges while in FAIL: code and counters stay frozen.
        repeat (60) tick();
        check("frozen.code", int'(bus.fail_code), int'(FC_NOEDGE));
        for (int i = 0; i < 3; i++) begin
            repeat (9) tick();
            toggle_tick();
        end
        check("frozen.code_after_edges", int'(bus.fail_code),  int'(FC_NOEDGE));
        check("frozen.toggles",          int'(bus.toggle_cnt), 0);
        check("frozen.state",            int'(bus.dbg_state),  int'(FAIL));

        // Asynchronous reset mid-MEASURE.
        bus.en = 1'b0;
        tick();
        bus.en = 1'b1;
        tick();
        toggle_tick();
        repeat (4) tick();
        toggle_tick();
        check("pre_rst.toggles",   int'(bus.toggle_cnt), 2);
        check("pre_rst.last_half", int'(bus.last_half),  5);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        bus.en = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
        check("post_rst.busy", int'(bus.busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
